// File: rtl/miriscv_mem_pkg.sv
// rtl/miriscv_mem_pkg.sv - shared types and constants for the data-memory path
//
// Purpose: FSM state encoding for the data-memory responder and the byte-enable
// patterns shared with the load/store unit.
// Ports: none (package).

package miriscv_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } dmem_state_e;

  localparam logic [3:0] BE_B0 = 4'b0001;
  localparam logic [3:0] BE_B1 = 4'b0010;
  localparam logic [3:0] BE_B2 = 4'b0100;
  localparam logic [3:0] BE_B3 = 4'b1000;
  localparam logic [3:0] BE_H0 = 4'b0011;
  localparam logic [3:0] BE_H1 = 4'b1100;
  localparam logic [3:0] BE_W  = 4'b1111;

  // Value loaded into the WAIT countdown at acceptance. LATENCY 1 skips WAIT
  // entirely, so the load value is irrelevant there and forced to 0.
  function automatic logic [1:0] latency_load(input int latency);
    if (latency >= 2) begin
      return 2'(latency - 2);
    end
    return 2'd0;
  endfunction

endpackage

// File: rtl/miriscv_bram_be.sv
// rtl/miriscv_bram_be.sv - single-port word array with per-byte write enables
//
// Purpose: DEPTH_WORDS x 32 storage. Writes are byte-lane masked; reads land
// in a synchronous read register.
// Ports:
//   clk_i    in  clock
//   arstn_i  in  synchronous active-low reset (clears the read register only)
//   en_i     in  access enable for this cycle
//   we_i     in  1 = write, 0 = read
//   be_i     in  byte lane enables for writes
//   addr_i   in  word index
//   wdata_i  in  write data
//   rdata_o  out read register contents

module miriscv_bram_be #(
  parameter int    DEPTH_WORDS = 1024,
  parameter string INIT_FILE   = "",
  localparam int   AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk_i,
  input  logic          arstn_i,
  input  logic          en_i,
  input  logic          we_i,
  input  logic [3:0]    be_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] rdata_q;

  // Array contents are deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (en_i && we_i) begin
      for (int n = 0; n < 4; n++) begin
        if (be_i[n]) begin
          mem[addr_i][8*n +: 8] <= wdata_i[8*n +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!arstn_i) begin
      rdata_q <= '0;
    end else if (en_i && !we_i) begin
      rdata_q <= mem[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/miriscv_dmem_responder.sv
// rtl/miriscv_dmem_responder.sv - data-memory responder for the core LSU port
//
// Purpose: grants one request at a time, performs the byte-enabled write or
// word read at acceptance, and returns one response pulse LATENCY cycles later.
// Ports:
//   clk_i         in  clock
//   arstn_i       in  synchronous active-low reset
//   data_req_i    in  request present, held until data_rvalid_o
//   data_we_i     in  1 = write, 0 = read
//   data_be_i     in  byte lane enables
//   data_addr_i   in  byte address (bits [1:0] ignored)
//   data_wdata_i  in  lane-replicated write data
//   data_gnt_o    out request accepted this cycle (combinational)
//   data_rvalid_o out one-cycle response pulse
//   data_rdata_o  out read data, zero unless a valid read response
//   data_err_o    out response error, zero unless data_rvalid_o

module miriscv_dmem_responder
  import miriscv_mem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          LATENCY     = 1,
  parameter string       INIT_FILE   = ""
) (
  input  logic        clk_i,
  input  logic        arstn_i,
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o
);

  localparam int          AW         = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN_BYTES = 32'(DEPTH_WORDS * 4);
  localparam logic [1:0]  CNT_LOAD   = latency_load(LATENCY);

  dmem_state_e state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        err_q;
  logic        is_read_q;

  logic [31:0]   offset;
  logic          in_range;
  logic [AW-1:0] word_idx;
  logic          accept;
  logic [31:0]   bram_rdata;

  // Unsigned subtraction: addresses below BASE_ADDR wrap to large offsets and
  // fail the range test without a separate lower-bound compare.
  assign offset   = data_addr_i - BASE_ADDR;
  assign in_range = (offset < SPAN_BYTES);
  assign word_idx = offset[AW+1:2];

  // Reset gates acceptance so nothing is granted or written while held.
  assign accept     = (state_q == ST_IDLE) && data_req_i && arstn_i;
  assign data_gnt_o = accept;

  miriscv_bram_be #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .INIT_FILE   (INIT_FILE)
  ) u_bram (
    .clk_i   (clk_i),
    .arstn_i (arstn_i),
    .en_i    (accept && in_range),
    .we_i    (data_we_i),
    .be_i    (data_be_i),
    .addr_i  (word_idx),
    .wdata_i (data_wdata_i),
    .rdata_o (bram_rdata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 2'd0) begin
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!arstn_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 2'd0;
      err_q     <= 1'b0;
      is_read_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        err_q     <= !in_range;
        // Only in-range reads return data; writes and errors respond with 0.
        is_read_q <= !data_we_i && in_range;
      end
    end
  end

  assign data_rvalid_o = (state_q == ST_RESP);
  assign data_rdata_o  = (data_rvalid_o && is_read_q) ? bram_rdata : 32'h0;
  assign data_err_o    = data_rvalid_o && err_q;

endmodule

// File: tb/tb_miriscv_dmem_responder.sv
// tb/tb_miriscv_dmem_responder.sv - directed bench for miriscv_dmem_responder

module tb_miriscv_dmem_responder;

  logic        clk;
  logic [2:0]  arstn;
  logic [2:0]  req;
  logic [2:0]  we;
  logic [3:0]  be_s   [3];
  logic [31:0] addr   [3];
  logic [31:0] wdata  [3];
  logic [2:0]  gnt;
  logic [2:0]  rvalid;
  logic [31:0] rdata  [3];
  logic [2:0]  err;

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instance 0: LATENCY 1, base 0, 1024 words
  miriscv_dmem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .LATENCY(1), .INIT_FILE("")) u_dut0 (
    .clk_i(clk), .arstn_i(arstn[0]), .data_req_i(req[0]), .data_we_i(we[0]),
    .data_be_i(be_s[0]), .data_addr_i(addr[0]), .data_wdata_i(wdata[0]),
    .data_gnt_o(gnt[0]), .data_rvalid_o(rvalid[0]), .data_rdata_o(rdata[0]), .data_err_o(err[0]));

  // Instance 1: LATENCY 3, base 0x1000, 16 words
  miriscv_dmem_responder #(.DEPTH_WORDS(16), .BASE_ADDR(32'h1000), .LATENCY(3), .INIT_FILE("")) u_dut1 (
    .clk_i(clk), .arstn_i(arstn[1]), .data_req_i(req[1]), .data_we_i(we[1]),
    .data_be_i(be_s[1]), .data_addr_i(addr[1]), .data_wdata_i(wdata[1]),
    .data_gnt_o(gnt[1]), .data_rvalid_o(rvalid[1]), .data_rdata_o(rdata[1]), .data_err_o(err[1]));

  // Instance 2: LATENCY 4, base 0, 1024 words
  miriscv_dmem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .LATENCY(4), .INIT_FILE("")) u_dut2 (
    .clk_i(clk), .arstn_i(arstn[2]), .data_req_i(req[2]), .data_we_i(we[2]),
    .data_be_i(be_s[2]), .data_addr_i(addr[2]), .data_wdata_i(wdata[2]),
    .data_gnt_o(gnt[2]), .data_rvalid_o(rvalid[2]), .data_rdata_o(rdata[2]), .data_err_o(err[2]));

  // Drives one request on instance k starting at posedge+1 and holds it until
  // the response is seen (bounded to 12 cycles). Returns cycle numbers relative
  // to the first request cycle (c0); -1 means never observed.
  task automatic run_txn(input int k, input logic w, input logic [3:0] b,
                         input logic [31:0] a, input logic [31:0] d,
                         output int first_gnt, output int gnt_cnt,
                         output int rv_cyc, output int rv_cnt,
                         output logic [31:0] rd, output logic er);
    bit done;
    first_gnt = -1; gnt_cnt = 0; rv_cyc = -1; rv_cnt = 0; rd = 32'h0; er = 1'b0; done = 1'b0;
    we[k] = w; be_s[k] = b; addr[k] = a; wdata[k] = d; req[k] = 1'b1;
    for (int c = 0; c < 12 && !done; c++) begin
      @(negedge clk);
      if (gnt[k]) begin
        if (first_gnt < 0) first_gnt = c;
        gnt_cnt++;
      end
      if (rvalid[k]) begin
        rv_cnt++; rv_cyc = c; rd = rdata[k]; er = err[k]; done = 1'b1;
      end
      @(posedge clk); #1;
    end
    req[k] = 1'b0;
  endtask

  task automatic test_reset();
    arstn = 3'b000; req = 3'b001; we = 3'b001;
    be_s[0] = 4'hF; addr[0] = 32'h20; wdata[0] = 32'hBAD0BAD0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL rst_gnt: got %b exp 000", gnt); end
    checks++; if (rvalid !== 3'b000) begin errors++; $display("FAIL rst_rvalid: got %b exp 000", rvalid); end
    checks++; if (err !== 3'b000) begin errors++; $display("FAIL rst_err: got %b exp 000", err); end
    checks++; if (rdata[0] !== 32'h0 || rdata[1] !== 32'h0 || rdata[2] !== 32'h0) begin
      errors++; $display("FAIL rst_rdata: got %h %h %h exp 0", rdata[0], rdata[1], rdata[2]);
    end
    @(posedge clk); #1;
    req = 3'b000; we = 3'b000; arstn = 3'b111;
  endtask

  task automatic test_write_read();
    int fg, gc, rc, rn; logic [31:0] rd; logic er;
    run_txn(0, 1'b1, 4'b1111, 32'h10, 32'hDEADBEEF, fg, gc, rc, rn, rd, er);
    checks++; if (fg !== 0) begin errors++; $display("FAIL wr_first_gnt: got %0d exp 0", fg); end
    checks++; if (gc !== 1) begin errors++; $display("FAIL wr_gnt_count: got %0d exp 1", gc); end
    checks++; if (rc !== 1 || rn !== 1) begin errors++; $display("FAIL wr_rvalid: cyc %0d cnt %0d exp cyc 1 cnt 1", rc, rn); end
    checks++; if (rd !== 32'h0 || er !== 1'b0) begin errors++; $display("FAIL wr_resp: rdata %h err %b exp 0 0", rd, er); end
    run_txn(0, 1'b0, 4'b0000, 32'h10, 32'h0, fg, gc, rc, rn, rd, er);
    checks++; if (fg !== 0 || rc !== 1) begin errors++; $display("FAIL rd_timing: gnt %0d rvalid %0d exp 0 1", fg, rc); end
    checks++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin errors++; $display("FAIL rd_data: rdata %h err %b exp deadbeef 0", rd, er); end
  endtask

  task automatic test_byte_lanes();
    int fg, gc, rc, rn; logic [31:0] rd; logic er;
    run_txn(0, 1'b1, 4'b0100, 32'h12, 32'h00AA0000, fg, gc, rc, rn, rd, er);
    run_txn(0, 1'b0, 4'b0000, 32'h10, 32'h0, fg, gc, rc, rn, rd, er);
    checks++; if (rd !== 32'hDEAABEEF) begin errors++; $display("FAIL byte2_write: got %h exp deaabeef", rd); end
    run_txn(0, 1'b1, 4'b1100, 32'h10, 32'h12340000, fg, gc, rc, rn, rd, er);
    run_txn(0, 1'b0, 4'b0000, 32'h10, 32'h0, fg, gc, rc, rn, rd, er);
    checks++; if (rd !== 32'h1234BEEF) begin errors++; $display("FAIL half_write: got %h exp 1234beef", rd); end
    run_txn(0, 1'b1, 4'b0000, 32'h10, 32'hFFFFFFFF, fg, gc, rc, rn, rd, er);
    checks++; if (rn !== 1 || rc !== 1 || er !== 1'b0) begin errors++; $display("FAIL be0_resp: cnt %0d cyc %0d err %b exp 1 1 0", rn, rc, er); end
    run_txn(0, 1'b0, 4'b0000, 32'h10, 32'h0, fg, gc, rc, rn, rd, er);
    checks++; if (rd !== 32'h1234BEEF) begin errors++; $display("FAIL be0_noop: got %h exp 1234beef", rd); end
  endtask

  task automatic test_out_of_range();
    int fg, gc, rc, rn; logic [31:0] rd; logic er;
    run_txn(0, 1'b1, 4'b1111, 32'hFFC, 32'hA5A5A5A5, fg, gc, rc, rn, rd, er);
    run_txn(0, 1'b1, 4'b1111, 32'h1000, 32'h12345678, fg, gc, rc, rn, rd, er);
    checks++; if (rn !== 1 || er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL oor_write: cnt %0d err %b rdata %h exp 1 1 0", rn, er, rd); end
    run_txn(0, 1'b0, 4'b0000, 32'hFFC, 32'h0, fg, gc, rc, rn, rd, er);
    checks++; if (rd !== 32'hA5A5A5A5 || er !== 1'b0) begin errors++; $display("FAIL last_word: rdata %h err %b exp a5a5a5a5 0", rd, er); end
    run_txn(0, 1'b0, 4'b0000, 32'h1000, 32'h0, fg, gc, rc, rn, rd, er);
    checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL oor_read: rdata %h err %b exp 0 1", rd, er); end
    // Below-base address on the offset instance wraps and must error.
    run_txn(1, 1'b0, 4'b0000, 32'hFFC, 32'h0, fg, gc, rc, rn, rd, er);
    checks++; if (er !== 1'b1 || rd !== 32'h0 || rc !== 3) begin errors++; $display("FAIL below_base: rdata %h err %b cyc %0d exp 0 1 3", rd, er, rc); end
    run_txn(1, 1'b1, 4'b1111, 32'h1040, 32'h0, fg, gc, rc, rn, rd, er);
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL above_top: err %b exp 1", er); end
  endtask

  task automatic test_latency3();
    int fg, gc, rc, rn; logic [31:0] rd; logic er;
    logic [7:0] gnt_seen, rv_seen;
    run_txn(1, 1'b1, 4'b1111, 32'h1008, 32'hCAFEF00D, fg, gc, rc, rn, rd, er);
    checks++; if (fg !== 0 || gc !== 1 || rc !== 3 || rn !== 1) begin
      errors++; $display("FAIL lat3_write: gnt %0d/%0d rvalid %0d/%0d exp 0/1 3/1", fg, gc, rc, rn);
    end
    run_txn(1, 1'b0, 4'b0000, 32'h103C, 32'h0, fg, gc, rc, rn, rd, er);
    checks++; if (er !== 1'b0 || rc !== 3) begin errors++; $display("FAIL lat3_top_word: err %b cyc %0d exp 0 3", er, rc); end
    // Request held continuously for two full transactions.
    gnt_seen = '0; rv_seen = '0;
    we[1] = 1'b0; be_s[1] = 4'b0000; addr[1] = 32'h1008; req[1] = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      gnt_seen[c] = gnt[1];
      rv_seen[c]  = rvalid[1];
      if (rvalid[1]) begin
        checks++; if (rdata[1] !== 32'hCAFEF00D) begin errors++; $display("FAIL lat3_rdata c%0d: got %h exp cafef00d", c, rdata[1]); end
      end
      @(posedge clk); #1;
    end
    req[1] = 1'b0;
    checks++; if (gnt_seen !== 8'b0001_0001) begin errors++; $display("FAIL lat3_gnt_pattern: got %b exp 00010001", gnt_seen); end
    checks++; if (rv_seen !== 8'b1000_1000) begin errors++; $display("FAIL lat3_rvalid_pattern: got %b exp 10001000", rv_seen); end
  endtask

  task automatic test_reset_in_wait();
    int fg, gc, rc, rn; logic [31:0] rd; logic er;
    int stray;
    we[2] = 1'b1; be_s[2] = 4'b1111; addr[2] = 32'h40; wdata[2] = 32'h600DCAFE; req[2] = 1'b1;
    @(negedge clk);
    checks++; if (gnt[2] !== 1'b1) begin errors++; $display("FAIL rw_gnt_c0: got %b exp 1", gnt[2]); end
    @(posedge clk); #1;
    @(posedge clk); #1;
    arstn[2] = 1'b0;
    @(negedge clk);
    checks++; if (rvalid[2] !== 1'b0 || gnt[2] !== 1'b0) begin errors++; $display("FAIL rw_c2: rvalid %b gnt %b exp 0 0", rvalid[2], gnt[2]); end
    @(posedge clk); #1;
    arstn[2] = 1'b1; req[2] = 1'b0;
    stray = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (rvalid[2]) stray++;
    end
    @(posedge clk); #1;
    checks++; if (stray !== 0) begin errors++; $display("FAIL rw_dropped_resp: got %0d rvalid pulses exp 0", stray); end
    run_txn(2, 1'b0, 4'b0000, 32'h40, 32'h0, fg, gc, rc, rn, rd, er);
    checks++; if (fg !== 0 || rc !== 4) begin errors++; $display("FAIL rw_read_timing: gnt %0d rvalid %0d exp 0 4", fg, rc); end
    checks++; if (rd !== 32'h600DCAFE || er !== 1'b0) begin errors++; $display("FAIL rw_persist: rdata %h err %b exp 600dcafe 0", rd, er); end
  endtask

  task automatic test_reset_blocks_write();
    int fg, gc, rc, rn; logic [31:0] rd; logic er;
    run_txn(0, 1'b1, 4'b1111, 32'h20, 32'h11111111, fg, gc, rc, rn, rd, er);
    arstn[0] = 1'b0;
    we[0] = 1'b1; be_s[0] = 4'b1111; addr[0] = 32'h20; wdata[0] = 32'hBAD0BAD0; req[0] = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++; if (gnt[0] !== 1'b0 || rvalid[0] !== 1'b0) begin errors++; $display("FAIL rst_hold c%0d: gnt %b rvalid %b exp 0 0", c, gnt[0], rvalid[0]); end
      @(posedge clk); #1;
    end
    req[0] = 1'b0; arstn[0] = 1'b1;
    run_txn(0, 1'b0, 4'b0000, 32'h20, 32'h0, fg, gc, rc, rn, rd, er);
    checks++; if (rd !== 32'h11111111) begin errors++; $display("FAIL rst_no_write: got %h exp 11111111", rd); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] gnt_seen, rv_seen;
    gnt_seen = '0; rv_seen = '0;
    we[0] = 1'b0; be_s[0] = 4'b0000; addr[0] = 32'h10; req[0] = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      gnt_seen[c] = gnt[0];
      rv_seen[c]  = rvalid[0];
      if (rvalid[0]) begin
        checks++; if (rdata[0] !== 32'h1234BEEF) begin errors++; $display("FAIL b2b_rdata c%0d: got %h exp 1234beef", c, rdata[0]); end
      end
      @(posedge clk); #1;
    end
    req[0] = 1'b0;
    checks++; if (gnt_seen !== 4'b0101) begin errors++; $display("FAIL b2b_gnt_pattern: got %b exp 0101", gnt_seen); end
    checks++; if (rv_seen !== 4'b1010) begin errors++; $display("FAIL b2b_rvalid_pattern: got %b exp 1010", rv_seen); end
  endtask

  initial begin
    arstn = 3'b000; req = 3'b000; we = 3'b000;
    for (int i = 0; i < 3; i++) begin
      be_s[i] = 4'h0; addr[i] = 32'h0; wdata[i] = 32'h0;
    end
    @(posedge clk); #1;
    test_reset();
    test_write_read();
    test_byte_lanes();
    test_out_of_range();
    test_latency3();
    test_reset_in_wait();
    test_reset_blocks_write();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
